decode_dispatch: RTL and testbench

//  Registered decode/dispatch stage between instruction fetch and issue (RS / LS queue). Decodes one RV32I

---
 rtl/decode_dispatch.sv | 234 +++++++++++++++++++++++
 tb/tb_decode_dispatch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_dispatch.sv
// decode_dispatch: registered RV32I decode / rename / operand-resolve stage.
//   Fetch side : in_valid/in_ready, in_inst, in_pc
//   ROB alloc  : rob_alloc_ok, rob_alloc_tag
//   Regfile    : rs1/rs2 (read addr), reg_val*/reg_busy*/reg_tag*, rename_ena/rd/tag
//   ROB lookup : query_tag*, rob_rdy*, rob_val*
//   CDB snoop  : cdb_valid, cdb_tag, cdb_data (NUM_CDB buses, packed)
//   Issue side : out_valid/out_ready plus the decoded, renamed entry (out_*)
//   flush kills the held entry and blocks acceptance for that cycle.
`ifndef OPERATION_BUS
`define OPERATION_BUS 5:0
`endif

module decode_dispatch #(
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic                       rob_alloc_ok,
    input  logic [ROB_W-1:0]           rob_alloc_tag,
    output logic [4:0]                 rs1,
    output logic [4:0]                 rs2,
    input  logic [DATA_W-1:0]          reg_val1,
    input  logic [DATA_W-1:0]          reg_val2,
    input  logic                       reg_busy1,
    input  logic                       reg_busy2,
    input  logic [ROB_W-1:0]           reg_tag1,
    input  logic [ROB_W-1:0]           reg_tag2,
    output logic [ROB_W-1:0]           query_tag1,
    output logic [ROB_W-1:0]           query_tag2,
    input  logic                       rob_rdy1,
    input  logic                       rob_rdy2,
    input  logic [DATA_W-1:0]          rob_val1,
    input  logic [DATA_W-1:0]          rob_val2,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]  cdb_data,
    output logic                       rename_ena,
    output logic [4:0]                 rename_rd,
    output logic [ROB_W-1:0]           rename_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`OPERATION_BUS]      out_op,
    output logic [DATA_W-1:0]          out_imm,
    output logic [DATA_W-1:0]          out_pc,
    output logic [4:0]                 out_rd,
    output logic [ROB_W-1:0]           out_rob_tag,
    output logic [DATA_W-1:0]          out_val1,
    output logic [DATA_W-1:0]          out_val2,
    output logic [ROB_W-1:0]           out_tag1,
    output logic [ROB_W-1:0]           out_tag2,
    output logic                       out_is_ls
);
    typedef logic [`OPERATION_BUS] op_t;
    localparam op_t OP_NOP = 0, OP_LUI = 1, OP_AUIPC = 2, OP_JAL = 3, OP_JALR = 4;
    localparam op_t OP_BEQ = 5, OP_BNE = 6, OP_BLT = 7, OP_BGE = 8, OP_BLTU = 9, OP_BGEU = 10;
    localparam op_t OP_LB = 11, OP_LH = 12, OP_LW = 13, OP_LBU = 14, OP_LHU = 15;
    localparam op_t OP_SB = 16, OP_SH = 17, OP_SW = 18;
    localparam op_t OP_ADDI = 19, OP_SLTI = 20, OP_SLTIU = 21, OP_XORI = 22, OP_ORI = 23;
    localparam op_t OP_ANDI = 24, OP_SLLI = 25, OP_SRLI = 26, OP_SRAI = 27;
    localparam op_t OP_ADD = 28, OP_SUB = 29, OP_SLL = 30, OP_SLT = 31, OP_SLTU = 32;
    localparam op_t OP_XOR = 33, OP_SRL = 34, OP_SRA = 35, OP_OR = 36, OP_AND = 37;

    // ---------------- decode ----------------
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        b30;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, d_imm;
    op_t         d_op;
    logic [4:0]  d_rd, d_rs1, d_rs2;
    logic        d_ls;

    assign opc   = in_inst[6:0];
    assign f3    = in_inst[14:12];
    assign b30   = in_inst[30];
    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    always_comb begin
        d_op  = OP_NOP;
        d_imm = '0;
        d_rd  = '0;
        d_rs1 = '0;
        d_rs2 = '0;
        d_ls  = 1'b0;
        case (opc)
            7'h37: begin d_op = OP_LUI;   d_imm = imm_u; d_rd = in_inst[11:7]; end
            7'h17: begin d_op = OP_AUIPC; d_imm = imm_u; d_rd = in_inst[11:7]; end
            7'h6F: begin d_op = OP_JAL;   d_imm = imm_j; d_rd = in_inst[11:7]; end
            7'h67: if (f3 == 3'd0) begin
                d_op = OP_JALR; d_imm = imm_i; d_rd = in_inst[11:7]; d_rs1 = in_inst[19:15];
            end
            7'h03: begin
                case (f3)
                    3'd0: d_op = OP_LB;  3'd1: d_op = OP_LH;  3'd2: d_op = OP_LW;
                    3'd4: d_op = OP_LBU; 3'd5: d_op = OP_LHU; default: d_op = OP_NOP;
                endcase
                if (d_op != OP_NOP) begin
                    d_imm = imm_i; d_rd = in_inst[11:7]; d_rs1 = in_inst[19:15]; d_ls = 1'b1;
                end
            end
            7'h23: begin
                case (f3)
                    3'd0: d_op = OP_SB; 3'd1: d_op = OP_SH; 3'd2: d_op = OP_SW;
                    default: d_op = OP_NOP;
                endcase
                if (d_op != OP_NOP) begin
                    d_imm = imm_s; d_rs1 = in_inst[19:15]; d_rs2 = in_inst[24:20]; d_ls = 1'b1;
                end
            end
            7'h63: begin
                case (f3)
                    3'd0: d_op = OP_BEQ; 3'd1: d_op = OP_BNE;  3'd4: d_op = OP_BLT;
                    3'd5: d_op = OP_BGE; 3'd6: d_op = OP_BLTU; 3'd7: d_op = OP_BGEU;
                    default: d_op = OP_NOP;
                endcase
                if (d_op != OP_NOP) begin
                    d_imm = imm_b; d_rs1 = in_inst[19:15]; d_rs2 = in_inst[24:20];
                end
            end
            7'h13: begin
                case (f3)
                    3'd0: d_op = OP_ADDI; 3'd1: d_op = OP_SLLI; 3'd2: d_op = OP_SLTI;
                    3'd3: d_op = OP_SLTIU; 3'd4: d_op = OP_XORI;
                    3'd5: d_op = b30 ? OP_SRAI : OP_SRLI;
                    3'd6: d_op = OP_ORI;  default: d_op = OP_ANDI;
                endcase
                d_imm = imm_i; d_rd = in_inst[11:7]; d_rs1 = in_inst[19:15];
            end
            7'h33: begin
                case (f3)
                    3'd0: d_op = b30 ? OP_SUB : OP_ADD; 3'd1: d_op = OP_SLL;
                    3'd2: d_op = OP_SLT; 3'd3: d_op = OP_SLTU; 3'd4: d_op = OP_XOR;
                    3'd5: d_op = b30 ? OP_SRA : OP_SRL;
                    3'd6: d_op = OP_OR;  default: d_op = OP_AND;
                endcase
                d_rd = in_inst[11:7]; d_rs1 = in_inst[19:15]; d_rs2 = in_inst[24:20];
            end
            default: ;
        endcase
    end

    // ---------------- handshake / rename ----------------
    logic accept;
    assign in_ready   = rob_alloc_ok & ~flush & (~out_valid | out_ready);
    assign accept     = in_valid & in_ready;
    assign rename_ena = accept & (d_rd != 5'd0);
    assign rename_rd  = d_rd;
    assign rename_tag = rob_alloc_tag;
    assign rs1        = d_rs1;
    assign rs2        = d_rs2;
    assign query_tag1 = reg_busy1 ? reg_tag1 : '0;
    assign query_tag2 = reg_busy2 ? reg_tag2 : '0;

    // ---------------- operand resolve ----------------
    // Returns {hit, data}; scanned high-to-low so the lowest bus index wins.
    function automatic logic [DATA_W:0] cdb_find(input logic [ROB_W-1:0] t,
            input logic [NUM_CDB-1:0] v, input logic [NUM_CDB*ROB_W-1:0] tg,
            input logic [NUM_CDB*DATA_W-1:0] dt);
        cdb_find = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--)
            if (v[k] && (t != '0) && (tg[k*ROB_W +: ROB_W] == t))
                cdb_find = {1'b1, dt[k*DATA_W +: DATA_W]};
    endfunction

    // Returns {tag, value} using the rs0 / regfile / ROB / CDB / pending priority.
    function automatic logic [ROB_W+DATA_W-1:0] resolve(input logic rs_nz, input logic busy,
            input logic [DATA_W-1:0] rval, input logic rrdy, input logic [DATA_W-1:0] rbv,
            input logic [ROB_W-1:0] tag, input logic [DATA_W:0] hit);
        if (!rs_nz)            resolve = '0;
        else if (!busy)        resolve = {{ROB_W{1'b0}}, rval};
        else if (rrdy)         resolve = {{ROB_W{1'b0}}, rbv};
        else if (hit[DATA_W])  resolve = {{ROB_W{1'b0}}, hit[DATA_W-1:0]};
        else                   resolve = {tag, {DATA_W{1'b0}}};
    endfunction

    logic [DATA_W:0]             src_hit1, src_hit2, wk_hit1, wk_hit2;
    logic [ROB_W+DATA_W-1:0]     res1, res2;
    assign src_hit1 = cdb_find(reg_tag1, cdb_valid, cdb_tag, cdb_data);
    assign src_hit2 = cdb_find(reg_tag2, cdb_valid, cdb_tag, cdb_data);
    assign wk_hit1  = cdb_find(out_tag1, cdb_valid, cdb_tag, cdb_data);
    assign wk_hit2  = cdb_find(out_tag2, cdb_valid, cdb_tag, cdb_data);
    assign res1 = resolve(d_rs1 != 5'd0, reg_busy1, reg_val1, rob_rdy1, rob_val1, reg_tag1, src_hit1);
    assign res2 = resolve(d_rs2 != 5'd0, reg_busy2, reg_val2, rob_rdy2, rob_val2, reg_tag2, src_hit2);

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_op      <= OP_NOP;
            out_imm     <= '0;
            out_pc      <= '0;
            out_rd      <= '0;
            out_rob_tag <= '0;
            out_val1    <= '0;
            out_val2    <= '0;
            out_tag1    <= '0;
            out_tag2    <= '0;
            out_is_ls   <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_op      <= d_op;
            out_imm     <= DATA_W'(d_imm);
            out_pc      <= in_pc;
            out_rd      <= d_rd;
            out_rob_tag <= rob_alloc_tag;
            out_val1    <= res1[DATA_W-1:0];
            out_tag1    <= res1[ROB_W+DATA_W-1:DATA_W];
            out_val2    <= res2[DATA_W-1:0];
            out_tag2    <= res2[ROB_W+DATA_W-1:DATA_W];
            out_is_ls   <= d_ls;
        end else begin
            // accept is already blocked by flush, so only the drain case remains
            if (flush || out_ready) out_valid <= 1'b0;
            if (wk_hit1[DATA_W]) begin
                out_val1 <= wk_hit1[DATA_W-1:0];
                out_tag1 <= '0;
            end
            if (wk_hit2[DATA_W]) begin
                out_val2 <= wk_hit2[DATA_W-1:0];
                out_tag2 <= '0;
            end
        end
    end
endmodule

// File: tb/tb_decode_dispatch.sv
// tb_decode_dispatch: directed spec scenarios followed by randomized traffic, checked
// against a transaction-level model of the stage. Instructions are assembled from a
// chosen operation and random fields; the expected decode is what was assembled.
module tb_decode_dispatch;
    localparam int DW = 32, RW = 4, NC = 2;

    logic clk, rst_n, flush, in_valid, in_ready, rob_alloc_ok;
    logic [31:0] in_inst;
    logic [DW-1:0] in_pc;
    logic [RW-1:0] rob_alloc_tag;
    logic [4:0] rs1, rs2;
    logic [DW-1:0] reg_val1, reg_val2, rob_val1, rob_val2;
    logic reg_busy1, reg_busy2, rob_rdy1, rob_rdy2;
    logic [RW-1:0] reg_tag1, reg_tag2, query_tag1, query_tag2;
    logic [NC-1:0] cdb_valid;
    logic [NC*RW-1:0] cdb_tag;
    logic [NC*DW-1:0] cdb_data;
    logic rename_ena, out_valid, out_ready, out_is_ls;
    logic [4:0] rename_rd, out_rd;
    logic [RW-1:0] rename_tag, out_rob_tag, out_tag1, out_tag2;
    logic [5:0] out_op;
    logic [DW-1:0] out_imm, out_pc, out_val1, out_val2;

    decode_dispatch #(.DATA_W(DW), .ROB_W(RW), .NUM_CDB(NC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .rob_alloc_ok(rob_alloc_ok), .rob_alloc_tag(rob_alloc_tag),
        .rs1(rs1), .rs2(rs2), .reg_val1(reg_val1), .reg_val2(reg_val2),
        .reg_busy1(reg_busy1), .reg_busy2(reg_busy2), .reg_tag1(reg_tag1), .reg_tag2(reg_tag2),
        .query_tag1(query_tag1), .query_tag2(query_tag2), .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2),
        .rob_val1(rob_val1), .rob_val2(rob_val2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .rename_ena(rename_ena), .rename_rd(rename_rd), .rename_tag(rename_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_imm(out_imm),
        .out_pc(out_pc), .out_rd(out_rd), .out_rob_tag(out_rob_tag), .out_val1(out_val1),
        .out_val2(out_val2), .out_tag1(out_tag1), .out_tag2(out_tag2), .out_is_ls(out_is_ls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // operation numbering of the issue-side op bus
    localparam int NOP = 0, ADDI = 19, ADD = 28, SW = 18, BEQ = 5;
    localparam int BR_F3 [6]  = '{0, 1, 4, 5, 6, 7};
    localparam int LD_F3 [5]  = '{0, 1, 2, 4, 5};
    localparam int OI_F3 [9]  = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
    localparam int OP_F3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    localparam int BAD_OPC [5] = '{'h7F, 'h73, 'h0F, 'h00, 'h2B};
    localparam int LD_BAD [3] = '{3, 6, 7};

    typedef struct {
        logic [31:0] inst; logic [5:0] op; logic [31:0] imm;
        logic [4:0] rd, rs1, rs2; logic ls;
    } gen_t;

    typedef struct {
        logic v; logic [5:0] op; logic [31:0] imm, pc, val1, val2;
        logic [4:0] rd; logic [3:0] robt, tag1, tag2; logic ls;
    } ent_t;

    int ncmp = 0, nerr = 0;
    gen_t cur;
    ent_t e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Assemble a valid instruction for operation number op (1..37).
    function automatic gen_t make(input int op);
        gen_t g;
        logic [6:0] opc; logic [2:0] f3; logic b30;
        logic [4:0] rd, a, b; logic [11:0] i12; logic [12:0] b13; logic [20:0] j21; logic [19:0] u20;
        rd = 5'($urandom); a = 5'($urandom); b = 5'($urandom);
        i12 = 12'($urandom); b13 = 13'($urandom) & ~13'd1; j21 = 21'($urandom) & ~21'd1; u20 = 20'($urandom);
        g = '{inst: 0, op: 6'(op), imm: 0, rd: 0, rs1: 0, rs2: 0, ls: 0};
        b30 = 1'b0; f3 = 3'd0;
        if (op == 1 || op == 2) begin
            opc = (op == 1) ? 7'h37 : 7'h17;
            g.inst = {u20, rd, opc}; g.imm = {u20, 12'b0}; g.rd = rd;
        end else if (op == 3) begin
            g.inst = {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'h6F};
            g.imm = {{11{j21[20]}}, j21}; g.rd = rd;
        end else if (op >= 5 && op <= 10) begin
            f3 = 3'(BR_F3[op-5]);
            g.inst = {b13[12], b13[10:5], b, a, f3, b13[4:1], b13[11], 7'h63};
            g.imm = {{19{b13[12]}}, b13}; g.rs1 = a; g.rs2 = b;
        end else if (op >= 16 && op <= 18) begin
            f3 = 3'(op - 16);
            g.inst = {i12[11:5], b, a, f3, i12[4:0], 7'h23};
            g.imm = {{20{i12[11]}}, i12}; g.rs1 = a; g.rs2 = b; g.ls = 1'b1;
        end else if (op >= 28) begin
            f3 = 3'(OP_F3[op-28]); b30 = (op == 29 || op == 35);
            g.inst = {1'b0, b30, 5'b0, b, a, f3, rd, 7'h33};
            g.rd = rd; g.rs1 = a; g.rs2 = b;
        end else begin
            if (op == 4) begin opc = 7'h67; f3 = 3'd0; end
            else if (op <= 15) begin opc = 7'h03; f3 = 3'(LD_F3[op-11]); g.ls = 1'b1; end
            else begin
                opc = 7'h13; f3 = 3'(OI_F3[op-19]);
                if (op >= 25) i12 = {1'b0, (op == 27), 5'b0, i12[4:0]};
            end
            g.inst = {i12, a, f3, rd, opc};
            g.imm = {{20{i12[11]}}, i12}; g.rd = rd; g.rs1 = a;
        end
        return g;
    endfunction

    // Undecodable words: unknown opcode or illegal funct3 for a known opcode.
    function automatic gen_t make_nop();
        gen_t g;
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[6:0] = 7'(BAD_OPC[$urandom_range(0, 4)]);
            1: begin w[6:0] = 7'h03; w[14:12] = 3'(LD_BAD[$urandom_range(0, 2)]); end
            2: begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(2, 3)); end
            default: begin w[6:0] = 7'h67; w[14:12] = 3'($urandom_range(1, 7)); end
        endcase
        g = '{inst: w, op: 6'(NOP), imm: 0, rd: 0, rs1: 0, rs2: 0, ls: 0};
        return g;
    endfunction

    function automatic void cdb_lookup(input logic [3:0] t, output logic hit, output logic [31:0] d);
        hit = 1'b0; d = '0;
        for (int k = 0; k < NC; k++)
            if (!hit && cdb_valid[k] && t != 4'd0 && cdb_tag[k*RW +: RW] == t) begin
                hit = 1'b1; d = cdb_data[k*DW +: DW];
            end
    endfunction

    function automatic void src_model(input logic [4:0] rs, input logic busy, input logic [31:0] rv,
            input logic rrdy, input logic [31:0] robv, input logic [3:0] tg,
            output logic [31:0] val, output logic [3:0] tag);
        logic hit; logic [31:0] d;
        cdb_lookup(tg, hit, d);
        val = '0; tag = '0;
        if (rs == 5'd0) ;
        else if (!busy) val = rv;
        else if (rrdy)  val = robv;
        else if (hit)   val = d;
        else            tag = tg;
    endfunction

    task automatic set_inst(input gen_t g);
        cur = g; in_inst = g.inst;
    endtask

    task automatic rand_drive();
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        flush = ($urandom_range(0, 15) == 0);
        rob_alloc_ok = ($urandom_range(0, 7) != 0);
        rob_alloc_tag = 4'($urandom_range(1, 15));
        set_inst(($urandom_range(0, 5) == 0) ? make_nop() : make($urandom_range(1, 37)));
        in_pc = $urandom;
        reg_val1 = $urandom; reg_val2 = $urandom; rob_val1 = $urandom; rob_val2 = $urandom;
        reg_busy1 = 1'($urandom); reg_busy2 = 1'($urandom);
        reg_tag1 = 4'($urandom_range(1, 3)); reg_tag2 = 4'($urandom_range(1, 3));
        rob_rdy1 = ($urandom_range(0, 3) == 0); rob_rdy2 = ($urandom_range(0, 3) == 0);
        cdb_valid = 2'($urandom);
        cdb_tag = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
        cdb_data = {$urandom, $urandom};
    endtask

    task automatic quiet_drive();
        in_valid = 0; out_ready = 1; flush = 0; rob_alloc_ok = 1; rob_alloc_tag = 4'd1;
        set_inst(make(ADDI)); in_pc = '0;
        reg_val1 = 0; reg_val2 = 0; rob_val1 = 0; rob_val2 = 0;
        reg_busy1 = 0; reg_busy2 = 0; reg_tag1 = 4'd1; reg_tag2 = 4'd1;
        rob_rdy1 = 0; rob_rdy2 = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    endtask

    task automatic chk_entry();
        chk("out_valid", 64'(out_valid), 64'(e.v));
        if (e.v) begin
            chk("out_op", 64'(out_op), 64'(e.op));
            chk("out_imm", 64'(out_imm), 64'(e.imm));
            chk("out_pc", 64'(out_pc), 64'(e.pc));
            chk("out_rd", 64'(out_rd), 64'(e.rd));
            chk("out_rob_tag", 64'(out_rob_tag), 64'(e.robt));
            chk("out_val1", 64'(out_val1), 64'(e.val1));
            chk("out_tag1", 64'(out_tag1), 64'(e.tag1));
            chk("out_val2", 64'(out_val2), 64'(e.val2));
            chk("out_tag2", 64'(out_tag2), 64'(e.tag2));
            chk("out_is_ls", 64'(out_is_ls), 64'(e.ls));
        end
    endtask

    // One clock: check combinational outputs, advance the model, check the register.
    task automatic tick();
        logic rdy, acc, hit; logic [31:0] d; ent_t n;
        #1;
        rdy = rob_alloc_ok & ~flush & (~e.v | out_ready);
        acc = in_valid & rdy;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("rename_ena", 64'(rename_ena), 64'(acc && cur.rd != 0));
        if (acc && cur.rd != 0) begin
            chk("rename_rd", 64'(rename_rd), 64'(cur.rd));
            chk("rename_tag", 64'(rename_tag), 64'(rob_alloc_tag));
        end
        chk("rs1", 64'(rs1), 64'(cur.rs1));
        chk("rs2", 64'(rs2), 64'(cur.rs2));
        chk("query_tag1", 64'(query_tag1), 64'(reg_busy1 ? reg_tag1 : 4'd0));
        chk("query_tag2", 64'(query_tag2), 64'(reg_busy2 ? reg_tag2 : 4'd0));
        n = e;
        if (acc) begin
            n.v = 1; n.op = cur.op; n.imm = cur.imm; n.pc = in_pc; n.rd = cur.rd;
            n.robt = rob_alloc_tag; n.ls = cur.ls;
            src_model(cur.rs1, reg_busy1, reg_val1, rob_rdy1, rob_val1, reg_tag1, n.val1, n.tag1);
            src_model(cur.rs2, reg_busy2, reg_val2, rob_rdy2, rob_val2, reg_tag2, n.val2, n.tag2);
        end else begin
            if (flush || out_ready) n.v = 0;
            cdb_lookup(e.tag1, hit, d); if (hit) begin n.val1 = d; n.tag1 = 0; end
            cdb_lookup(e.tag2, hit, d); if (hit) begin n.val2 = d; n.tag2 = 0; end
        end
        @(posedge clk); #1;
        e = n;
        chk_entry();
    endtask

    task automatic model_reset();
        e = '{v: 0, op: 6'(NOP), imm: 0, pc: 0, val1: 0, val2: 0, rd: 0, robt: 0, tag1: 0, tag2: 0, ls: 0};
    endtask

    initial begin
        gen_t g;
        // reset state
        rst_n = 0; quiet_drive(); model_reset();
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_op", 64'(out_op), 64'(NOP));
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_tag1", 64'(out_tag1), 64'd0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // ADDI x5,x0,-1 @0x100, tag 3
        g = '{inst: {12'hFFF, 5'd0, 3'd0, 5'd5, 7'h13}, op: 6'(ADDI), imm: 32'hFFFF_FFFF,
              rd: 5'd5, rs1: 5'd0, rs2: 5'd0, ls: 0};
        set_inst(g); in_valid = 1; in_pc = 32'h100; rob_alloc_tag = 4'd3;
        tick();
        chk("t1_imm", 64'(out_imm), 64'hFFFF_FFFF);

        // ADD x3,x1,x2: x1 waits on tag 2, CDB0 broadcasts tag 2 the same cycle
        g = '{inst: {7'd0, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, op: 6'(ADD), imm: 0,
              rd: 5'd3, rs1: 5'd1, rs2: 5'd2, ls: 0};
        set_inst(g); rob_alloc_tag = 4'd5; reg_busy1 = 1; reg_tag1 = 4'd2; rob_rdy1 = 0;
        reg_val2 = 32'h1234; cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd2}; cdb_data = {32'd0, 32'h55};
        tick();
        chk("t2_val1", 64'(out_val1), 64'h55);
        chk("t2_tag1", 64'(out_tag1), 64'd0);

        // hold with tag2 = 4, wake up via CDB1 two cycles later
        reg_busy1 = 0; reg_busy2 = 1; reg_tag2 = 4'd4; rob_rdy2 = 0; cdb_valid = 0;
        tick();
        chk("t3_tag2", 64'(out_tag2), 64'd4);
        in_valid = 0; out_ready = 0;
        tick(); tick();
        cdb_valid = 2'b10; cdb_tag = {4'd4, 4'd0}; cdb_data = {32'hAB, 32'd0};
        tick();
        chk("t3_val2", 64'(out_val2), 64'hAB);
        chk("t3_tag2w", 64'(out_tag2), 64'd0);

        // flush while an entry is held and fetch is valid
        cdb_valid = 0; in_valid = 1; flush = 1; out_ready = 1;
        tick();
        chk("t4_valid", 64'(out_valid), 64'd0);
        flush = 0;

        // SW x2,-4(x1) and BEQ x1,x2,-8
        g = '{inst: {7'h7F, 5'd2, 5'd1, 3'd2, 5'h1C, 7'h23}, op: 6'(SW), imm: 32'hFFFF_FFFC,
              rd: 0, rs1: 5'd1, rs2: 5'd2, ls: 1};
        set_inst(g); reg_busy2 = 0;
        tick();
        chk("t5_sw_ls", 64'(out_is_ls), 64'd1);
        g = '{inst: {1'b1, 6'h3F, 5'd2, 5'd1, 3'd0, 4'hC, 1'b1, 7'h63}, op: 6'(BEQ), imm: 32'hFFFF_FFF8,
              rd: 0, rs1: 5'd1, rs2: 5'd2, ls: 0};
        set_inst(g);
        tick();
        chk("t5_beq_imm", 64'(out_imm), 64'hFFFF_FFF8);

        // asynchronous reset in the middle of a hold
        out_ready = 0; in_valid = 0;
        tick();
        #2 rst_n = 0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_op", 64'(out_op), 64'(NOP));
        model_reset();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        g = '{inst: 32'hFFFF_FFFF, op: 6'(NOP), imm: 0, rd: 0, rs1: 0, rs2: 0, ls: 0};
        set_inst(g); in_valid = 1; out_ready = 1;
        tick();
        chk("t6_nop_rd", 64'(out_rd), 64'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_drive();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
